crc_stream_engine: RTL and testbench

- Parameterised, streaming CRC engine. Accepts a framed data stream with a valid/ready handshake, one DATA_W beat per cycle.
- Produces the final CRC of each frame, with beat count, through a valid/ready result port.
- Generalises the team's fixed 8-bit CRC-8 generator to any width, polynomial, init, final-XOR and bit reflection.
- Sits between the packet framer and the link transmit/receive path.

---
 rtl/crc_pkg.sv | 24 ++
 rtl/crc_stream_engine_if.sv | 32 +++
 rtl/crc_step_comb.sv | 35 +++
 rtl/crc_stream_engine.sv | 150 +++++++++++++++
 tb/tb_crc_stream_engine.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/crc_pkg.sv
// Shared types, common polynomials and bit-reverse helper for the CRC stream engine.
package crc_pkg;

  localparam logic [7:0]  CRC8        = 8'h07;
  localparam logic [15:0] CRC16_CCITT = 16'h1021;
  localparam logic [31:0] CRC32       = 32'h04C11DB7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Reverses the low w bits of x; bits above w come back as zero.
  function automatic logic [63:0] bit_rev(input logic [63:0] x, input int unsigned w);
    logic [63:0] r;
    r = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i < w) r[6'(i)] = x[6'(w - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/crc_stream_engine_if.sv
// Stream-in / result-out bundle of the CRC stream engine.
// CRC_CHECK_EN adds the chk_crc / m_match checker signals.
interface crc_stream_engine_if #(
  parameter int unsigned CRC_W  = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_sop;
  logic              s_eop;
  logic              m_valid;
  logic              m_ready;
  logic [CRC_W-1:0]  m_crc;
  logic [CNT_W-1:0]  m_beats;
  logic              m_restart;
`ifdef CRC_CHECK_EN
  logic [CRC_W-1:0]  chk_crc;
  logic              m_match;

  modport master (output s_valid, s_data, s_sop, s_eop, m_ready, chk_crc,
                  input  s_ready, m_valid, m_crc, m_beats, m_restart, m_match);
  modport slave  (input  s_valid, s_data, s_sop, s_eop, m_ready, chk_crc,
                  output s_ready, m_valid, m_crc, m_beats, m_restart, m_match);
`else
  modport master (output s_valid, s_data, s_sop, s_eop, m_ready,
                  input  s_ready, m_valid, m_crc, m_beats, m_restart);
  modport slave  (input  s_valid, s_data, s_sop, s_eop, m_ready,
                  output s_ready, m_valid, m_crc, m_beats, m_restart);
`endif
endinterface

// File: rtl/crc_step_comb.sv
// One-beat combinational CRC update: MSB-first long division of DATA_W bits through POLY.
module crc_step_comb #(
  parameter int unsigned      CRC_W      = 8,
  parameter int unsigned      DATA_W     = 8,
  parameter logic [CRC_W-1:0] POLY       = CRC_W'(8'h07),
  parameter bit               REFLECT_IN = 1'b0
) (
  input  logic [CRC_W-1:0]  crc_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [CRC_W-1:0]  crc_c_o
);

  logic [DATA_W-1:0] data_msb;
  logic [CRC_W-1:0]  c;
  logic [DATA_W-1:0] d;
  logic              fb;

  // Put the first wire bit at the top so the divider always consumes MSB-first.
  for (genvar g = 0; g < DATA_W; g++) begin : g_order
    assign data_msb[g] = REFLECT_IN ? data_i[DATA_W-1-g] : data_i[g];
  end

  always_comb begin
    c  = crc_i;
    d  = data_msb;
    fb = 1'b0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      fb = c[CRC_W-1] ^ d[DATA_W-1];
      c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
      d  = d << 1;
    end
    crc_c_o = c;
  end

endmodule

// File: rtl/crc_stream_engine.sv
// Streaming CRC engine: framed valid/ready beats in, registered CRC + beat count out.
// Define CRC_CHECK_EN to compare the final CRC against chk_crc (m_match).
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int unsigned      CRC_W       = 8,
  parameter int unsigned      DATA_W      = 8,
  parameter logic [CRC_W-1:0] POLY        = CRC_W'(CRC8),
  parameter logic [CRC_W-1:0] INIT        = '0,
  parameter logic [CRC_W-1:0] XOR_OUT     = '0,
  parameter bit               REFLECT_IN  = 1'b0,
  parameter bit               REFLECT_OUT = 1'b0,
  parameter int unsigned      CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  crc_stream_engine_if.slave    bus
);

  state_e             state_q, state_d;
  logic [CRC_W-1:0]   crc_q, crc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rflag_q, rflag_d;
  logic               s_ready_q, s_ready_d;
  logic               m_valid_q, m_valid_d;
  logic [CRC_W-1:0]   m_crc_q, m_crc_d;
  logic [CNT_W-1:0]   m_beats_q, m_beats_d;
  logic               m_restart_q, m_restart_d;
  logic               accept_c;
  logic [CRC_W-1:0]   step_in_c, step_out_c, final_c;
`ifdef CRC_CHECK_EN
  logic               m_match_q, m_match_d;
`endif

  assign accept_c  = bus.s_valid && s_ready_q;
  // A frame restarts from INIT unless it is a continuation beat in ACCUM.
  assign step_in_c = (state_q == ACCUM && !bus.s_sop) ? crc_q : INIT;

  crc_step_comb #(
    .CRC_W      (CRC_W),
    .DATA_W     (DATA_W),
    .POLY       (POLY),
    .REFLECT_IN (REFLECT_IN)
  ) u_step (
    .crc_i   (step_in_c),
    .data_i  (bus.s_data),
    .crc_c_o (step_out_c)
  );

  always_comb begin
    final_c = REFLECT_OUT ? CRC_W'(bit_rev(64'(step_out_c), CRC_W)) : step_out_c;
    final_c = final_c ^ XOR_OUT;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      crc_q       <= INIT;
      cnt_q       <= '0;
      rflag_q     <= 1'b0;
      s_ready_q   <= 1'b1;
      m_valid_q   <= 1'b0;
      m_crc_q     <= '0;
      m_beats_q   <= '0;
      m_restart_q <= 1'b0;
`ifdef CRC_CHECK_EN
      m_match_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      cnt_q       <= cnt_d;
      rflag_q     <= rflag_d;
      s_ready_q   <= s_ready_d;
      m_valid_q   <= m_valid_d;
      m_crc_q     <= m_crc_d;
      m_beats_q   <= m_beats_d;
      m_restart_q <= m_restart_d;
`ifdef CRC_CHECK_EN
      m_match_q   <= m_match_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    cnt_d       = cnt_q;
    rflag_d     = rflag_q;
    m_crc_d     = m_crc_q;
    m_beats_d   = m_beats_q;
    m_restart_d = m_restart_q;
`ifdef CRC_CHECK_EN
    m_match_d   = m_match_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          crc_d   = step_out_c;
          cnt_d   = CNT_W'(1);
          rflag_d = 1'b0;
          state_d = bus.s_eop ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept_c) begin
          crc_d = step_out_c;
          if (bus.s_sop) begin
            cnt_d   = CNT_W'(1);
            rflag_d = 1'b1;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (bus.s_eop) state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.m_ready) begin
          state_d = IDLE;
          crc_d   = INIT;
          cnt_d   = '0;
          rflag_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Capture the result on the eop beat so outputs are stable throughout HOLD.
    if (state_d == HOLD && state_q != HOLD) begin
      m_crc_d     = final_c;
      m_beats_d   = cnt_d;
      m_restart_d = rflag_d;
`ifdef CRC_CHECK_EN
      m_match_d   = (final_c == bus.chk_crc);
`endif
    end
    s_ready_d = (state_d != HOLD);
    m_valid_d = (state_d == HOLD);
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_crc     = m_crc_q;
  assign bus.m_beats   = m_beats_q;
  assign bus.m_restart = m_restart_q;
`ifdef CRC_CHECK_EN
  assign bus.m_match   = m_match_q;
`endif

endmodule

// File: tb/tb_crc_stream_engine.sv
// Directed bench for crc_stream_engine: CRC-8, CRC-16/CCITT, CRC-32 and a narrow-counter
// instance share one stimulus stream; CRC_CHECK_EN enables the checker-mode vectors.
module tb_crc_stream_engine;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       s_valid, s_sop, s_eop, m_ready;
  logic [7:0] s_data;
  logic [7:0] chk_crc;
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  crc_stream_engine_if #(.CRC_W(8),  .DATA_W(8), .CNT_W(16)) if8  ();
  crc_stream_engine_if #(.CRC_W(16), .DATA_W(8), .CNT_W(16)) if16 ();
  crc_stream_engine_if #(.CRC_W(32), .DATA_W(8), .CNT_W(16)) if32 ();
  crc_stream_engine_if #(.CRC_W(8),  .DATA_W(8), .CNT_W(2))  ifs  ();

  assign if8.s_valid  = s_valid;  assign if8.s_data  = s_data;  assign if8.s_sop  = s_sop;
  assign if8.s_eop    = s_eop;    assign if8.m_ready = m_ready;
  assign if16.s_valid = s_valid;  assign if16.s_data = s_data;  assign if16.s_sop = s_sop;
  assign if16.s_eop   = s_eop;    assign if16.m_ready = m_ready;
  assign if32.s_valid = s_valid;  assign if32.s_data = s_data;  assign if32.s_sop = s_sop;
  assign if32.s_eop   = s_eop;    assign if32.m_ready = m_ready;
  assign ifs.s_valid  = s_valid;  assign ifs.s_data  = s_data;  assign ifs.s_sop  = s_sop;
  assign ifs.s_eop    = s_eop;    assign ifs.m_ready = m_ready;
`ifdef CRC_CHECK_EN
  assign if8.chk_crc  = chk_crc;
  assign if16.chk_crc = '0;
  assign if32.chk_crc = '0;
  assign ifs.chk_crc  = chk_crc;
`endif

  crc_stream_engine u_dut8 (.clk(clk), .reset_n(reset_n), .bus(if8.slave));

  crc_stream_engine #(.CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF)) u_dut16 (
    .clk(clk), .reset_n(reset_n), .bus(if16.slave));

  crc_stream_engine #(.CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF),
                      .XOR_OUT(32'hFFFFFFFF), .REFLECT_IN(1'b1), .REFLECT_OUT(1'b1)) u_dut32 (
    .clk(clk), .reset_n(reset_n), .bus(if32.slave));

  crc_stream_engine #(.CNT_W(2)) u_dut_sat (.clk(clk), .reset_n(reset_n), .bus(ifs.slave));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic send_beat(input logic [7:0] d, input logic sop, input logic eop);
    bit acc = 1'b0;
    int n   = 0;
    s_valid = 1'b1; s_data = d; s_sop = sop; s_eop = eop;
    while (!acc && n < 100) begin
      acc = if8.s_ready;
      @(posedge clk); #1;
      n++;
    end
    s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
    if (!acc) check("accept_timeout", 64'(0), 64'(1));
  endtask

  task automatic send_str(input bit gaps);
    for (int i = 0; i < 9; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_beat(8'(8'h31 + i), i == 0, i == 8);
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!if8.m_valid && n < 100) begin @(posedge clk); #1; n++; end
    check("valid_timeout", 64'(if8.m_valid), 64'(1));
  endtask

  task automatic take_result();
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    check("post_take_m_valid", 64'(if8.m_valid), 64'(0));
    check("post_take_s_ready", 64'(if8.s_ready), 64'(1));
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #1;
    check("rst_m_valid", 64'(if8.m_valid), 64'(0));
    check("rst_s_ready", 64'(if8.s_ready), 64'(1));
    check("rst_m_crc",   64'(if8.m_crc),   64'(0));
    check("rst_m_beats", 64'(if8.m_beats), 64'(0));
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  logic [7:0]  rc [2];
  logic [15:0] rb [2];

  initial begin
    reset_n = 1'b0; s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
    s_data = 8'h00; m_ready = 1'b0; chk_crc = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_s_ready",   64'(if8.s_ready),   64'(1));
    check("reset_m_valid",   64'(if8.m_valid),   64'(0));
    check("reset_m_crc",     64'(if8.m_crc),     64'(0));
    check("reset_m_beats",   64'(if8.m_beats),   64'(0));
    check("reset_m_restart", 64'(if8.m_restart), 64'(0));
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // "123456789" through all four engines, result held off for five cycles.
    send_str(1'b0);
    check("latency_m_valid", 64'(if8.m_valid),   64'(1));
    check("crc8",            64'(if8.m_crc),     64'(8'hF4));
    check("crc8_beats",      64'(if8.m_beats),   64'(9));
    check("crc8_restart",    64'(if8.m_restart), 64'(0));
    check("crc16",           64'(if16.m_crc),    64'(16'h29B1));
    check("crc32",           64'(if32.m_crc),    64'(32'hCBF43926));
    check("sat_beats",       64'(ifs.m_beats),   64'(3));
    check("sat_crc",         64'(ifs.m_crc),     64'(8'hF4));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_crc16",    64'(if16.m_crc),    64'(16'h29B1));
      check("hold_s_ready",  64'(if16.s_ready),  64'(0));
      check("hold_m_valid",  64'(if16.m_valid),  64'(1));
    end
    take_result();

    // Mid-frame restart.
    send_beat(8'hAA, 1'b1, 1'b0);
    send_beat(8'hBB, 1'b0, 1'b0);
    send_beat(8'hCC, 1'b0, 1'b0);
    send_str(1'b0);
    wait_valid();
    check("restart_crc",   64'(if8.m_crc),     64'(8'hF4));
    check("restart_beats", 64'(if8.m_beats),   64'(9));
    check("restart_flag",  64'(if8.m_restart), 64'(1));
    take_result();

    // Single-beat frame then a gapped frame while the consumer toggles m_ready.
    fork
      begin
        send_beat(8'h00, 1'b1, 1'b1);
        send_str(1'b1);
      end
      begin
        int got = 0;
        int cyc = 0;
        while (got < 2 && cyc < 400) begin
          m_ready = 1'($urandom_range(0, 1));
          if (if8.m_valid && m_ready) begin
            rc[got] = if8.m_crc;
            rb[got] = if8.m_beats;
            got++;
          end
          @(posedge clk); #1;
          cyc++;
        end
        m_ready = 1'b0;
        check("b2b_result_count", 64'(got), 64'(2));
      end
    join
    check("b2b_first_crc",    64'(rc[0]), 64'(8'h00));
    check("b2b_first_beats",  64'(rb[0]), 64'(1));
    check("b2b_second_crc",   64'(rc[1]), 64'(8'hF4));
    check("b2b_second_beats", 64'(rb[1]), 64'(9));

    // Reset mid-frame, then in HOLD; each followed by a clean frame.
    send_beat(8'h31, 1'b1, 1'b0);
    send_beat(8'h32, 1'b0, 1'b0);
    pulse_reset();
    send_str(1'b0);
    wait_valid();
    check("after_midrst_crc",   64'(if8.m_crc),   64'(8'hF4));
    check("after_midrst_beats", 64'(if8.m_beats), 64'(9));
    pulse_reset();
    send_str(1'b0);
    wait_valid();
    check("after_holdrst_crc",     64'(if8.m_crc),     64'(8'hF4));
    check("after_holdrst_restart", 64'(if8.m_restart), 64'(0));
    take_result();

`ifdef CRC_CHECK_EN
    chk_crc = 8'hF4;
    send_str(1'b0);
    wait_valid();
    check("match_hit", 64'(if8.m_match), 64'(1));
    take_result();
    chk_crc = 8'hF5;
    send_str(1'b0);
    wait_valid();
    check("match_miss", 64'(if8.m_match), 64'(0));
    take_result();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
